serial_frame_transmitter: RTL

- Parallel-to-serial transmitter for the 11-bit framed serial link: start bit, 8 data bits LSB first, parity bit, stop bit.
- Latches a byte on request, computes parity, and drives the data line one bit per falling edge of the externally supplied serial clock (CONTROL_CLOCK).
- Sits on the controller side opposite the frame receiver. Its frames must be accepted bit-exactly by that receiver.

---
 rtl/serial_frame_transmitter_if.sv | 21 ++
 rtl/serial_frame_transmitter.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_frame_transmitter_if.sv
// Byte-request / serial-link signal bundle shared by the frame transmitter and its driver.
`timescale 1ns/1ps
interface serial_frame_transmitter_if;
    logic       CONTROL_CLOCK;
    logic       SEND_REQUEST;
    logic [7:0] PARALLEL_DATA_INPUT;
    logic       SERIAL_DATA_OUTPUT;
    logic       BUSY;
    logic       SEND_DONE;
    logic [3:0] OUTPUT_COUNTER_REGISTER;

    modport master (
        output CONTROL_CLOCK, SEND_REQUEST, PARALLEL_DATA_INPUT,
        input  SERIAL_DATA_OUTPUT, BUSY, SEND_DONE, OUTPUT_COUNTER_REGISTER
    );

    modport slave (
        input  CONTROL_CLOCK, SEND_REQUEST, PARALLEL_DATA_INPUT,
        output SERIAL_DATA_OUTPUT, BUSY, SEND_DONE, OUTPUT_COUNTER_REGISTER
    );
endinterface

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial transmitter: start, 8 data bits LSB first, parity, stop,
// one bit per falling edge of the synchronized CONTROL_CLOCK.
`timescale 1ns/1ps
module serial_frame_transmitter #(
    parameter int FRAME_SIZE  = 11,
    parameter bit PARITY_ODD  = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input logic FCLK,
    input logic RESET,
    serial_frame_transmitter_if.slave link
);
    typedef enum logic [1:0] {IDLE, SHIFT, STOP_HOLD, DONE} state_t;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_SIZE - 1);

    logic       sync_reg [SYNC_STAGES];
    logic       prev_reg;
    logic       synced;
    logic       fall_edge;
    logic       parity_bit;

    state_t      state_reg, state_next;
    logic [10:0] frame_reg, frame_next;
    logic [3:0]  counter_reg, counter_next;
    logic        sdo_reg, sdo_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    // Synchronizer chain idles high so reset never fabricates a falling edge.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge FCLK) begin
                if (RESET)
                    sync_reg[gi] <= 1'b1;
                else if (gi == 0)
                    sync_reg[gi] <= link.CONTROL_CLOCK;
                else
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign synced     = sync_reg[SYNC_STAGES-1];
    assign fall_edge  = prev_reg & ~synced;
    assign parity_bit = PARITY_ODD ? ~^link.PARALLEL_DATA_INPUT : ^link.PARALLEL_DATA_INPUT;

    always_ff @(posedge FCLK) begin
        if (RESET) begin
            prev_reg    <= 1'b1;
            state_reg   <= IDLE;
            frame_reg   <= 11'h7FF;
            counter_reg <= 4'd0;
            sdo_reg     <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            prev_reg    <= synced;
            state_reg   <= state_next;
            frame_reg   <= frame_next;
            counter_reg <= counter_next;
            sdo_reg     <= sdo_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        frame_next   = frame_reg;
        counter_next = counter_reg;
        sdo_next     = sdo_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                sdo_next = 1'b1;
                // A fall_edge coinciding with acceptance is deliberately dropped.
                if (link.SEND_REQUEST) begin
                    frame_next   = {1'b1, parity_bit, link.PARALLEL_DATA_INPUT, 1'b0};
                    counter_next = 4'd0;
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_edge) begin
                    sdo_next     = frame_reg[0];
                    frame_next   = {1'b1, frame_reg[10:1]};
                    counter_next = counter_reg + 4'd1;
                    if (counter_reg == LAST_BIT)
                        state_next = STOP_HOLD;
                end
            end
            STOP_HOLD: begin
                // Line already carries the stop bit; hold it one more link period.
                if (fall_edge) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    counter_next = 4'd0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign link.SERIAL_DATA_OUTPUT      = sdo_reg;
    assign link.BUSY                    = busy_reg;
    assign link.SEND_DONE               = done_reg;
    assign link.OUTPUT_COUNTER_REGISTER = counter_reg;
endmodule
